enc_event_arbiter: RTL
======================

// Module: enc_event_arbiter
// PURPOSE
//  Merges N encoder-reader event streams (timestamp + line state per edge) into one AXI-Stream for the DMA/FIFO path.
//  Each channel has a one-entry capture slot, because readers emit 1-cycle tvalid pulses and do not honour tready.
//  Full slots are drained by a round-robin arbiter into a registered output stage.
//  Per-channel sticky overflow flags report events lost while that channel's slot was occupied.
// PARAMETERS
//  N_CH     4   number of encoder channels (2..16)
//  TS_W     64  timestamp width, equal to the shared free-running counter width
//  CH_W     $clog2(N_CH)  channel index width (localparam, not overridable)
// PORTS
//  clk            in   1          system clock; all logic on its rising edge
//  reset          in   1          synchronous, active-high reset
//  enable         in   1          1 = accept new events; 0 = ignore inputs, keep draining held slots
//  s_axis_tvalid  in   N_CH       per-channel event pulse from each reader
//  s_axis_tdata   in   N_CH*TS_W  per-channel timestamp; channel i at [i*TS_W +: TS_W]
//  s_axis_tuser   in   N_CH       per-channel line state after the edge
//  m_axis_tdata   out  TS_W       timestamp of the granted event
//  m_axis_tuser   out  CH_W+1     {channel index, line state}
//  m_axis_tvalid  out  1          output word valid
//  m_axis_tready  in   1          downstream ready
//  ovf_clear      in   1          pulse: clear all overflow flags
//  overflow       out  N_CH       sticky: channel i dropped at least one event
// BEHAVIOUR
//  Reset: all slots empty; m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, overflow=0, rr pointer=N_CH-1 (ch0 first).
//  Capture: at the edge where s_axis_tvalid[i]=1 and enable=1, the slot stores {tdata,tuser} if it is empty or drained that cycle.
//  Drop: if s_axis_tvalid[i]=1, enable=1, and the slot is full and not drained that cycle, the event is discarded and overflow[i] is set.
//  Overflow set and ovf_clear in the same cycle: set wins.
//  Output stage is "free" when m_axis_tvalid=0 or (m_axis_tvalid & m_axis_tready).
//  When free, the arbiter picks the first full slot at (ptr+1 .. ptr+N_CH) mod N_CH.
//    The pick loads the output regs, sets tvalid=1, empties that slot and sets ptr=picked.
//    If no slot is full, tvalid drops to 0 after the handshake.
//  Handshake: the output holds tdata/tuser/tvalid stable while tvalid=1 and tready=0 (AXI-S rule).
//    tvalid never depends combinationally on tready.
//  Latency: input pulse at cycle t -> slot full after edge t -> earliest tvalid=1 after edge t+1 (2 cycles).
//  Throughput: one word per cycle while slots are full and tready=1.
//  Simultaneous capture and drain on one channel: the new event lands in the slot; no drop.
//  Simultaneous pulses on all channels: every channel captures; output order follows rr from ptr+1.
//  Timestamps are passed through untouched. No arithmetic; wrap-around of the counter is the consumer's concern.
//  enable=0: slots and output keep draining normally; no new captures; overflow is not set.
//  reset asserted mid-transfer: the output word and all held events are discarded on that edge, with no partial word.
// STRUCTURE
//  Shared package enc_pkg: TS_W default and the m_axis_tuser field layout constants (CH_LSB, STATE_BIT).
//  Sub-module enc_rr_arbiter: N_CH request vector + advance strobe -> one-hot grant + index, with registered pointer.
//  Top level holds the N_CH capture slots, overflow flags and the output register.
// TESTING
//  1 Reset, then ch1 pulse ts=0x100 st=1 -> 2 cycles later tdata=0x100, tuser={1,1}; then overflow=0.
//  2 ch0..3 pulse in same cycle with ts=10..13, tready=1 -> 4 consecutive words, channels 0,1,2,3.
//    Next burst starts at ptr+1.
//  3 tready=0 and ch2 pulses ts=5 then ts=6 three cycles later.
//    Expect: word ts=5 held stable, ts=6 captured, no overflow.
//    A third pulse ts=7 -> dropped, overflow[2]=1.
//    Release tready -> ts=5 then ts=6 out.
//  4 ovf_clear in same cycle as a new drop on ch3 -> overflow[3] stays 1.
//    Next lone ovf_clear -> overflow=0.
//  5 enable=0 with ch0 pulse ts=0x20 -> no output word, overflow=0.
//    A word already held when enable falls still drains.
//  6 reset asserted while tvalid=1 and tready=0 -> next cycle tvalid=0.
//    All slots empty; no stale word after release.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared definitions for the encoder event merge path.
//   TS_W_DEF  : default timestamp width (width of the shared free-running counter)
//   STATE_BIT : position of the line-state bit in m_axis_tuser
//   CH_LSB    : lowest bit of the channel-index field in m_axis_tuser
//   wrap_idx  : (base + off) mod n without a divider, valid for base < n and off <= n
package enc_pkg;

    localparam int TS_W_DEF  = 64;
    localparam int STATE_BIT = 0;
    localparam int CH_LSB    = 1;

    function automatic int wrap_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/enc_rr_arbiter.sv
// Round-robin arbiter over N_CH requests.
//   clk, reset : system clock, synchronous active-high reset
//   req        : one bit per channel, 1 = channel has a held event
//   advance    : 1 = the grant is consumed this cycle (pointer moves to it)
//   gnt        : one-hot grant, first requester after the pointer
//   gnt_idx    : binary index of the granted channel
//   gnt_any    : 1 = some channel is granted
// The pointer holds the last consumed channel; after reset it sits at N_CH-1
// so channel 0 has first priority.
module enc_rr_arbiter
    import enc_pkg::*;
#(
    parameter  int N_CH = 4,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   req,
    input  logic              advance,
    output logic [N_CH-1:0]   gnt,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              gnt_any
);

    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] cand;

    // Scan ptr+1 .. ptr+N_CH; the first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N_CH; k++) begin
            cand = CH_W'(wrap_idx(int'(ptr), k, N_CH));
            if (!gnt_any && req[cand]) begin
                gnt_any    = 1'b1;
                gnt[cand]  = 1'b1;
                gnt_idx    = cand;
            end
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= CH_W'(N_CH - 1);
        end else if (advance && gnt_any) begin
            ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/enc_event_arbiter.sv
// Merges N_CH encoder-reader event streams into one AXI-Stream.
//   clk, reset      : system clock, synchronous active-high reset
//   enable          : 1 = accept new events, 0 = only drain what is held
//   s_axis_tvalid   : per-channel 1-cycle event pulse (readers ignore ready)
//   s_axis_tdata    : per-channel timestamp, channel i at [i*TS_W +: TS_W]
//   s_axis_tuser    : per-channel line state after the edge
//   m_axis_tdata    : timestamp of the output word
//   m_axis_tuser    : {channel index, line state}
//   m_axis_tvalid   : output word valid
//   m_axis_tready   : downstream ready
//   ovf_clear       : pulse, clears all overflow flags (a same-cycle set wins)
//   overflow        : sticky per-channel "event lost" flags
// Each channel owns a one-entry slot because readers cannot be back-pressured.
// A slot drained by the arbiter in a cycle may accept a new event that same
// cycle, so a steady one-event-per-two-cycles source never drops.
module enc_event_arbiter
    import enc_pkg::*;
#(
    parameter  int N_CH = 4,
    parameter  int TS_W = TS_W_DEF,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N_CH-1:0]      s_axis_tvalid,
    input  logic [N_CH*TS_W-1:0] s_axis_tdata,
    input  logic [N_CH-1:0]      s_axis_tuser,
    output logic [TS_W-1:0]      m_axis_tdata,
    output logic [CH_W:0]        m_axis_tuser,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    input  logic                 ovf_clear,
    output logic [N_CH-1:0]      overflow
);

    logic [N_CH-1:0] slot_full;
    logic [TS_W-1:0] slot_ts [N_CH];
    logic [N_CH-1:0] slot_st;

    logic            out_free;
    logic [N_CH-1:0] gnt;
    logic [CH_W-1:0] gnt_idx;
    logic            gnt_any;
    logic [N_CH-1:0] drain;
    logic [N_CH-1:0] capture;
    logic [N_CH-1:0] drop;
    logic [CH_W:0]   tuser_next;

    // The output register may take a new word when empty or being accepted.
    assign out_free = !m_axis_tvalid || m_axis_tready;

    enc_rr_arbiter #(.N_CH(N_CH)) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (slot_full),
        .advance (out_free),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign drain   = gnt & {N_CH{out_free}};
    assign capture = {N_CH{enable}} & s_axis_tvalid & (~slot_full | drain);
    assign drop    = {N_CH{enable}} & s_axis_tvalid & slot_full & ~drain;

    always_comb begin
        tuser_next                   = '0;
        tuser_next[STATE_BIT]        = slot_st[gnt_idx];
        tuser_next[CH_LSB +: CH_W]   = gnt_idx;
    end

    // Capture stage: slot occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_full <= '0;
            overflow  <= '0;
        end else begin
            slot_full <= (slot_full & ~drain) | capture;
            overflow  <= drop | (overflow & ~{N_CH{ovf_clear}});
        end
    end

    // Slot payload is only meaningful while slot_full is set, so it is not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (capture[i]) begin
                slot_ts[i] <= s_axis_tdata[i*TS_W +: TS_W];
                slot_st[i] <= s_axis_tuser[i];
            end
        end
    end

    // Output stage: registered AXI-Stream word, held while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
        end else if (out_free) begin
            m_axis_tvalid <= gnt_any;
            if (gnt_any) begin
                m_axis_tdata <= slot_ts[gnt_idx];
                m_axis_tuser <= tuser_next;
            end
        end
    end

endmodule
